ccg_parity_pipe: RTL and testbench

CCG_PARITY_PIPE -- requirements
Module: ccg_parity_pipe

---
 rtl/ccg_parity_pipe.sv | 96 +++++++++
 tb/tb_ccg_parity_pipe.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ccg_parity_pipe.sv
// ccg_parity_pipe: two-stage configurable parity/AND reduction pipeline with per-channel config.
module ccg_parity_pipe #(
  parameter int N_IN = 29,
  parameter int N_OUT = 27,
  parameter int CNT_W = 16,
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [N_IN-1:0]  cfg_mask,
  input  logic             cfg_mode,
  input  logic             cfg_inv,
  output logic [CNT_W-1:0] res_count
);
  logic [N_IN-1:0]  mask_q [N_OUT];
  logic [N_IN-1:0]  mask_d [N_OUT];
  logic [N_OUT-1:0] mode_q, mode_d, inv_q, inv_d;
  logic [N_IN-1:0]  s1_mask_q [N_OUT];
  logic [N_IN-1:0]  s1_mask_d [N_OUT];
  logic [N_OUT-1:0] s1_mode_q, s1_mode_d, s1_inv_q, s1_inv_d;
  logic [N_IN-1:0]  s1_x_q, s1_x_d;
  logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [N_OUT-1:0] f_q, f_d, f_calc;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             s2_load, s1_adv;
  assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
  assign s1_adv    = !s1_valid_q || s2_load;
  assign in_ready  = !(s1_valid_q && out_valid_q && !out_ready);
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign res_count = res_count_q;
  // Out-of-range cfg_idx matches no channel, so the write is dropped.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    inv_d  = inv_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (cfg_we && cfg_idx == IW'(k)) begin
        mask_d[k] = cfg_mask;
        mode_d[k] = cfg_mode;
        inv_d[k]  = cfg_inv;
      end
    end
  end
  // S1 snapshots the pre-write configuration alongside x.
  always_comb begin
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_x_d     = s1_adv ? x : s1_x_q;
    s1_mask_d  = s1_adv ? mask_q : s1_mask_q;
    s1_mode_d  = s1_adv ? mode_q : s1_mode_q;
    s1_inv_d   = s1_adv ? inv_q : s1_inv_q;
  end
  always_comb begin
    f_calc = '0;
    for (int k = 0; k < N_OUT; k++)
      f_calc[k] = (s1_mode_q[k] ? &(s1_x_q | ~s1_mask_q[k]) : ^(s1_x_q & s1_mask_q[k])) ^ s1_inv_q[k];
    f_d         = s2_load ? f_calc : f_q;
    out_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    res_count_d = res_count_q + CNT_W'(out_valid_q && out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '{default: '1};
      mode_q      <= '0;
      inv_q       <= '0;
      s1_mask_q   <= '{default: '0};
      s1_mode_q   <= '0;
      s1_inv_q    <= '0;
      s1_x_q      <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      res_count_q <= '0;
    end else begin
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      inv_q       <= inv_d;
      s1_mask_q   <= s1_mask_d;
      s1_mode_q   <= s1_mode_d;
      s1_inv_q    <= s1_inv_d;
      s1_x_q      <= s1_x_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      res_count_q <= res_count_d;
    end
  end
endmodule

// File: tb/tb_ccg_parity_pipe.sv
// tb_ccg_parity_pipe: directed checks of ccg_parity_pipe with N_IN=4, N_OUT=2, CNT_W=2.
module tb_ccg_parity_pipe;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] x, cfg_mask;
  logic [1:0] f, res_count;
  logic       cfg_we, cfg_idx, cfg_mode, cfg_inv;
  int n_chk = 0;
  int n_fail = 0;
  ccg_parity_pipe #(.N_IN(4), .N_OUT(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .cfg_inv(cfg_inv),
    .res_count(res_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic idx, input logic [3:0] m, input logic md, input logic iv);
    cfg_we = 1'b1; cfg_idx = idx; cfg_mask = m; cfg_mode = md; cfg_inv = iv;
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0;
    cfg_we = 1'b0; cfg_idx = 1'b0; cfg_mask = '0; cfg_mode = 1'b0; cfg_inv = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_f", 32'(f), 0);
    chk("rst_count", 32'(res_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    step(); step();
    rst_n = 1'b1;
    chk("rel_in_ready", 32'(in_ready), 1);
    x = 4'b1011; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_s1_only", 32'(out_valid), 0);
    step();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_f", 32'(f), 32'b11);
    step();
    chk("t1_count", 32'(res_count), 1);
    chk("t1_drained", 32'(out_valid), 0);
    cfg(1'b0, 4'b0011, 1'b1, 1'b1);
    step();
    cfg(1'b1, 4'b1100, 1'b0, 1'b0);
    step();
    cfg_we = 1'b0; x = 4'b0111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t2_f", 32'(f), 32'b10);
    step();
    chk("t2_count", 32'(res_count), 2);
    out_ready = 1'b0; in_valid = 1'b1; x = 4'b0001;
    step();
    x = 4'b0011;
    step();
    chk("t3_in_ready_low", 32'(in_ready), 0);
    x = 4'b0100;
    step(); step(); step();
    chk("t3_hold_valid", 32'(out_valid), 1);
    chk("t3_hold_f_a", 32'(f), 32'b01);
    chk("t3_stall_ready", 32'(in_ready), 0);
    chk("t3_stall_count", 32'(res_count), 2);
    out_ready = 1'b1;
    #1;
    chk("t3_ready_comb", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t3_f_b", 32'(f), 32'b00);
    chk("t3_count_a", 32'(res_count), 3);
    step();
    chk("t3_f_c", 32'(f), 32'b11);
    chk("t3_count_wrap", 32'(res_count), 0);
    step();
    chk("t3_count_5", 32'(res_count), 1);
    chk("t3_drained", 32'(out_valid), 0);
    cfg(1'b0, 4'b1111, 1'b0, 1'b0);
    x = 4'b0110; in_valid = 1'b1;
    step();
    cfg_we = 1'b0;
    step();
    in_valid = 1'b0;
    chk("t4_a_oldcfg", 32'(f), 32'b11);
    step();
    chk("t4_b_newcfg", 32'(f), 32'b10);
    step();
    chk("t4_count", 32'(res_count), 3);
    out_ready = 1'b0; in_valid = 1'b1; x = 4'b1000;
    step(); step();
    in_valid = 1'b0;
    chk("t5_full_valid", 32'(out_valid), 1);
    chk("t5_full_ready", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_valid), 0);
    chk("t5_async_count", 32'(res_count), 0);
    chk("t5_async_f", 32'(f), 0);
    chk("t5_async_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    rst_n = 1'b1;
    step(); step(); step();
    chk("t5_no_stale", 32'(out_valid), 0);
    chk("t5_no_count", 32'(res_count), 0);
    x = 4'b1011; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t5_default_cfg", 32'(f), 32'b11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
